uart_tx_arbiter: RTL

Round-robin arbiter that shares one uart_tx instance between NUM_REQ byte producers.
- Accepts one byte per grant, drives the transmitter's start_tx/data_in, and waits for tx_done.
- Reports per-requester completion or timeout.
- Sits between the system's message sources (status logger, command responder, etc.) and the single UART transmitter.

---
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// One byte per grant; waits for the transmitter's tx_done rise or a timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int IW            = $clog2(NUM_REQ),
    localparam int TW            = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   done,
    output logic                 timeout_err,
    output logic                 busy,
    output logic [IW-1:0]        grant_id,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_done
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        RELEASE
    } state_t;

    state_t              state;
    logic [IW-1:0]       ptr;
    logic [TW-1:0]       timer;
    logic                tx_done_q;
    logic                rise;
    logic [IW-1:0]       win;
    logic [IW-1:0]       cand;
    logic [7:0]          win_data;
    logic [NUM_REQ-1:0]  win_hot;
    logic [NUM_REQ-1:0]  gnt_hot;

    assign rise = tx_done & ~tx_done_q;

    // Scan farthest-to-nearest from ptr+1 so the nearest active request wins.
    always_comb begin
        win  = ptr;
        cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(ptr) + k) % NUM_REQ);
            if (req[cand]) win = cand;
        end
    end

    always_comb begin
        win_data = '0;
        win_hot  = '0;
        gnt_hot  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IW'(i)) begin
                win_data   = req_data[8*i +: 8];
                win_hot[i] = 1'b1;
            end
            if (grant_id == IW'(i)) gnt_hot[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ack         <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            ptr         <= IW'(NUM_REQ - 1);
            timer       <= '0;
            tx_done_q   <= 1'b0;
        end else begin
            ack         <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            tx_done_q   <= tx_done;
            case (state)
                IDLE: begin
                    if (|req) begin
                        ack      <= win_hot;
                        tx_data  <= win_data;
                        grant_id <= win;
                        ptr      <= win;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    tx_start <= 1'b0;
                    timer    <= '0;
                    state    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A rise on the final timer cycle still counts as success.
                    if (rise) begin
                        done  <= gnt_hot;
                        state <= RELEASE;
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!tx_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
